// File: rtl/nv_nvdla_reset_gen_if.sv
// CSB/core-facing signal bundle of the DLA reset generator.
// The master drives requests and the idle level; the slave (the generator) reports status.
interface nv_nvdla_reset_gen_if;
  logic test_mode;
  logic sw_reset_req;
  logic core_idle;
  logic timeout_clr;
  logic dla_reset_rstn;
  logic sw_reset_busy;
  logic sw_reset_done;
  logic timeout_flag;

  modport master (
    output test_mode, sw_reset_req, core_idle, timeout_clr,
    input  dla_reset_rstn, sw_reset_busy, sw_reset_done, timeout_flag
  );

  modport slave (
    input  test_mode, sw_reset_req, core_idle, timeout_clr,
    output dla_reset_rstn, sw_reset_busy, sw_reset_done, timeout_flag
  );
endinterface

// File: rtl/nv_nvdla_reset_gen.sv
// DLA core reset sequencer: drain (with timeout), assert for a fixed width, then settle.
// Power-on runs ASSERT/SETTLE from reset without producing a done pulse.
module nv_nvdla_reset_gen #(
  parameter int ASSERT_CYCLES = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int CNT_W         = 11
) (
  input  logic                    nvdla_clk,
  input  logic                    nvdla_rstn,
  nv_nvdla_reset_gen_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    ASSERT = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ASSERT_LOAD = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pending;
  logic             w_pending_nxt;
  logic             r_rstn;
  logic             r_timeout;
  logic             w_timeout_set;
  logic             w_cnt_zero;
  logic             w_done;

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    w_timeout_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.sw_reset_req) begin
          w_state_nxt   = DRAIN;
          w_cnt_nxt     = DRAIN_LOAD;
          w_pending_nxt = 1'b0;
        end
      end
      DRAIN: begin
        if (bus.core_idle) begin
          w_state_nxt = ASSERT;
          w_cnt_nxt   = ASSERT_LOAD;
        end else if (w_cnt_zero) begin
          w_timeout_set = 1'b1;
          w_state_nxt   = ASSERT;
          w_cnt_nxt     = ASSERT_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ASSERT: begin
        if (w_cnt_zero) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = SETTLE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (w_cnt_zero) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Reset lands directly in ASSERT so power-on shares the software release path.
  always_ff @(posedge nvdla_clk or negedge nvdla_rstn) begin
    if (!nvdla_rstn) begin
      r_state   <= ASSERT;
      r_cnt     <= ASSERT_LOAD;
      r_pending <= 1'b1;
      r_rstn    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
      r_rstn    <= (w_state_nxt != ASSERT);
      r_timeout <= w_timeout_set | (r_timeout & ~bus.timeout_clr);
    end
  end

  // Done marks the last SETTLE cycle of a software-initiated sequence only.
  assign w_done = (r_state == SETTLE) && w_cnt_zero && !r_pending;

  assign bus.dla_reset_rstn = bus.test_mode ? nvdla_rstn : r_rstn;
  assign bus.sw_reset_busy  = (r_state != IDLE);
  assign bus.sw_reset_done  = w_done;
  assign bus.timeout_flag   = r_timeout;

endmodule
